// File: rtl/apb_cmd_master.sv
// Command-to-APB bridge: takes one read/write command at a time, runs a single
// APB SETUP/ACCESS pair, waits RD_LAT cycles for registered read data, then holds a response.
module apb_cmd_master #(
    parameter int unsigned RD_LAT = 1
) (
    input  logic        pclk,
    input  logic        preset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_write,
    output logic [31:0] rsp_rdata,
    output logic [31:0] paddr,
    output logic [31:0] pwdata,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    input  logic [31:0] prdata,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
        WAIT,
        RESP
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [2:0] wait_cnt;
    logic       wait_last;
    logic       accept;

    assign wait_last = (wait_cnt == 3'(RD_LAT - 1));
    assign accept    = cmd_valid && cmd_ready;
    assign rsp_write = pwrite;
    assign busy      = (state != IDLE);

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        psel      = 1'b0;
        penable   = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                // Not ready while reset is held, even though the state is already IDLE.
                cmd_ready = !preset;
                if (cmd_valid && !preset) state_nxt = SETUP;
            end
            SETUP: begin
                psel      = 1'b1;
                state_nxt = ACCESS;
            end
            ACCESS: begin
                psel      = 1'b1;
                penable   = 1'b1;
                state_nxt = pwrite ? RESP : WAIT;
            end
            WAIT: begin
                if (wait_last) state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            paddr     <= '0;
            pwdata    <= '0;
            pwrite    <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state <= state_nxt;
            // The APB address/data/direction registers double as the latched command.
            if (accept) begin
                paddr     <= cmd_addr;
                pwdata    <= cmd_wdata;
                pwrite    <= cmd_write;
                rsp_rdata <= '0;
            end
            if (state == ACCESS) wait_cnt <= '0;
            if (state == WAIT) begin
                wait_cnt <= wait_cnt + 3'd1;
                if (wait_last) rsp_rdata <= prdata;
            end
        end
    end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master: two instances (RD_LAT=1 and RD_LAT=3),
// each attached to a small registered-read APB slave model.
module tb_apb_cmd_master;

    logic        pclk;
    logic        preset;
    logic        cmd_valid [2];
    logic        cmd_ready [2];
    logic        cmd_write [2];
    logic [31:0] cmd_addr  [2];
    logic [31:0] cmd_wdata [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic        rsp_write [2];
    logic [31:0] rsp_rdata [2];
    logic [31:0] paddr     [2];
    logic [31:0] pwdata    [2];
    logic        psel      [2];
    logic        penable   [2];
    logic        pwrite    [2];
    logic [31:0] prdata    [2];
    logic        busy      [2];

    logic [31:0] s_cntrl [2];
    logic [31:0] s_r8    [2];
    logic [31:0] s_r10   [2];

    int errors = 0;
    int checks = 0;

    apb_cmd_master #(.RD_LAT(1)) dut1 (
        .pclk(pclk), .preset(preset),
        .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_write(cmd_write[0]),
        .cmd_addr(cmd_addr[0]), .cmd_wdata(cmd_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_write(rsp_write[0]),
        .rsp_rdata(rsp_rdata[0]),
        .paddr(paddr[0]), .pwdata(pwdata[0]), .psel(psel[0]), .penable(penable[0]),
        .pwrite(pwrite[0]), .prdata(prdata[0]), .busy(busy[0])
    );

    apb_cmd_master #(.RD_LAT(3)) dut3 (
        .pclk(pclk), .preset(preset),
        .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_write(cmd_write[1]),
        .cmd_addr(cmd_addr[1]), .cmd_wdata(cmd_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_write(rsp_write[1]),
        .rsp_rdata(rsp_rdata[1]),
        .paddr(paddr[1]), .pwdata(pwdata[1]), .psel(psel[1]), .penable(penable[1]),
        .pwrite(pwrite[1]), .prdata(prdata[1]), .busy(busy[1])
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    function automatic logic [31:0] slave_rd(input int i, input logic [31:0] a);
        case (a)
            32'h0:   return s_cntrl[i];
            32'h4:   return 32'h5A5A_0000;
            32'h8:   return s_r8[i];
            32'hC:   return 32'hA5A5_0000;
            32'h10:  return s_r10[i];
            default: return 32'h0;
        endcase
    endfunction

    // Slave registers read data on the ACCESS edge; reset wins over a same-edge write.
    always @(posedge pclk) begin
        for (int i = 0; i < 2; i++) begin
            if (preset) begin
                s_cntrl[i] <= 32'h0;
                s_r8[i]    <= 32'h0;
                s_r10[i]   <= 32'h0000_FFFF;
                prdata[i]  <= 32'h0;
            end else if (psel[i] && penable[i]) begin
                if (pwrite[i]) begin
                    case (paddr[i])
                        32'h0:   s_cntrl[i] <= pwdata[i];
                        32'h8:   s_r8[i]    <= pwdata[i];
                        32'h10:  s_r10[i]   <= pwdata[i];
                        default: ;
                    endcase
                end else begin
                    prdata[i] <= slave_rd(i, paddr[i]);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of the IDLE cycle after RESP.
    task automatic do_cmd(input int i, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input int hold, input int exp_lat,
                          input logic [31:0] exp_rd, input string tag);
        int lat = 0;
        int n_setup = 0;
        int n_access = 0;
        int n_idle = 0;
        int bad = 0;
        logic [31:0] rd0;
        chk({tag, "_ready"}, 32'(cmd_ready[i]), 32'h1);
        cmd_valid[i] = 1'b1;
        cmd_write[i] = wr;
        cmd_addr[i]  = addr;
        cmd_wdata[i] = wdata;
        @(posedge pclk);
        #1;
        // Keep offering a different command to prove inputs are ignored mid-transaction.
        cmd_write[i] = ~wr;
        cmd_addr[i]  = 32'hFFFF_FFFC;
        cmd_wdata[i] = 32'hFFFF_FFFF;
        for (int k = 1; k <= 20; k++) begin
            @(negedge pclk);
            if (rsp_valid[i]) begin
                lat = k;
                break;
            end
            if (penable[i] && !psel[i]) bad++;
            if (psel[i] && (paddr[i] !== addr || pwdata[i] !== wdata || pwrite[i] !== wr)) bad++;
            if (psel[i] && !penable[i]) n_setup++;
            else if (psel[i] && penable[i]) n_access++;
            else n_idle++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_setup_cycles"}, 32'(n_setup), 32'h1);
        chk({tag, "_access_cycles"}, 32'(n_access), 32'h1);
        chk({tag, "_wait_cycles"}, 32'(n_idle), 32'(exp_lat - 3));
        chk({tag, "_apb_fields"}, 32'(bad), 32'h0);
        chk({tag, "_rsp_write"}, 32'(rsp_write[i]), 32'(wr));
        chk({tag, "_rsp_rdata"}, rsp_rdata[i], exp_rd);
        rd0 = rsp_rdata[i];
        for (int h = 0; h < hold; h++) begin
            @(negedge pclk);
            chk({tag, "_hold_flags"}, {29'b0, rsp_valid[i], cmd_ready[i], busy[i]}, 32'h5);
            chk({tag, "_hold_rdata"}, rsp_rdata[i], rd0);
        end
        cmd_valid[i] = 1'b0;
        rsp_ready[i] = 1'b1;
        @(posedge pclk);
        #1;
        rsp_ready[i] = 1'b0;
        @(negedge pclk);
        chk({tag, "_idle_flags"},
            {27'b0, rsp_valid[i], busy[i], cmd_ready[i], psel[i], penable[i]}, 32'h4);
        chk({tag, "_paddr_held"}, paddr[i], addr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        preset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cmd_valid[i] = 1'b0;
            cmd_write[i] = 1'b0;
            cmd_addr[i]  = 32'h0;
            cmd_wdata[i] = 32'h0;
            rsp_ready[i] = 1'b0;
        end
        repeat (2) @(posedge pclk);
        @(negedge pclk);
        for (int i = 0; i < 2; i++) begin
            chk("reset_flags", {25'b0, psel[i], penable[i], pwrite[i], rsp_valid[i],
                                rsp_write[i], busy[i], cmd_ready[i]}, 32'h0);
            chk("reset_paddr", paddr[i], 32'h0);
            chk("reset_pwdata", pwdata[i], 32'h0);
            chk("reset_rsp_rdata", rsp_rdata[i], 32'h0);
        end
        @(posedge pclk);
        #1;
        preset = 1'b0;
        @(negedge pclk);
        chk("post_reset_ready", 32'(cmd_ready[0]), 32'h1);

        do_cmd(0, 1'b0, 32'h4, 32'h0, 0, 4, 32'h5A5A_0000, "rd4");
        do_cmd(0, 1'b1, 32'h8, 32'hDEAD_BEEF, 0, 3, 32'h0, "wr8");
        do_cmd(0, 1'b0, 32'h8, 32'h0, 0, 4, 32'hDEAD_BEEF, "rd8");
        do_cmd(0, 1'b0, 32'hC, 32'h0, 5, 4, 32'hA5A5_0000, "rdC_bp");

        // Reset lands on the ACCESS edge of a write to 0x10.
        cmd_valid[0] = 1'b1;
        cmd_write[0] = 1'b1;
        cmd_addr[0]  = 32'h10;
        cmd_wdata[0] = 32'h1234_5678;
        @(posedge pclk);
        #1;
        cmd_valid[0] = 1'b0;
        @(negedge pclk);
        @(negedge pclk);
        chk("abort_in_access", {30'b0, psel[0], penable[0]}, 32'h3);
        preset = 1'b1;
        @(posedge pclk);
        #1;
        preset = 1'b0;
        @(negedge pclk);
        chk("abort_next", {28'b0, psel[0], penable[0], rsp_valid[0], busy[0]}, 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge pclk);
            chk("abort_no_rsp", 32'(rsp_valid[0]), 32'h0);
        end
        do_cmd(0, 1'b0, 32'h10, 32'h0, 0, 4, 32'h0000_FFFF, "rd10");

        do_cmd(0, 1'b0, 32'h14, 32'h0, 0, 4, 32'h0, "rd14_unmapped");
        do_cmd(0, 1'b1, 32'h0, 32'h0000_000F, 0, 3, 32'h0, "wr0");
        do_cmd(0, 1'b0, 32'h0, 32'h0, 0, 4, 32'h0000_000F, "rd0");

        do_cmd(1, 1'b0, 32'h4, 32'h0, 0, 6, 32'h5A5A_0000, "lat3_rd4");
        do_cmd(1, 1'b1, 32'h8, 32'h0BAD_F00D, 2, 3, 32'h0, "lat3_wr8");
        do_cmd(1, 1'b0, 32'h8, 32'h0, 0, 6, 32'h0BAD_F00D, "lat3_rd8");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
